// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 round controller:
// round constants, initial hash values, FSM state encoding.
package sha256_pkg;

  localparam int ROUNDS = 64;
  localparam int CNT_W  = $clog2(ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: 6-bit round index to K[t].
module sha256_k_rom (
  input  logic [5:0]  idx_i,
  output logic [31:0] k_o
);

  // Constant table as a flat case so synthesis folds it into LUTs.
  always_comb begin
    k_o = '0;
    case (idx_i)
      6'd0:  k_o = 32'h428a2f98; 6'd1:  k_o = 32'h71374491; 6'd2:  k_o = 32'hb5c0fbcf; 6'd3:  k_o = 32'he9b5dba5;
      6'd4:  k_o = 32'h3956c25b; 6'd5:  k_o = 32'h59f111f1; 6'd6:  k_o = 32'h923f82a4; 6'd7:  k_o = 32'hab1c5ed5;
      6'd8:  k_o = 32'hd807aa98; 6'd9:  k_o = 32'h12835b01; 6'd10: k_o = 32'h243185be; 6'd11: k_o = 32'h550c7dc3;
      6'd12: k_o = 32'h72be5d74; 6'd13: k_o = 32'h80deb1fe; 6'd14: k_o = 32'h9bdc06a7; 6'd15: k_o = 32'hc19bf174;
      6'd16: k_o = 32'he49b69c1; 6'd17: k_o = 32'hefbe4786; 6'd18: k_o = 32'h0fc19dc6; 6'd19: k_o = 32'h240ca1cc;
      6'd20: k_o = 32'h2de92c6f; 6'd21: k_o = 32'h4a7484aa; 6'd22: k_o = 32'h5cb0a9dc; 6'd23: k_o = 32'h76f988da;
      6'd24: k_o = 32'h983e5152; 6'd25: k_o = 32'ha831c66d; 6'd26: k_o = 32'hb00327c8; 6'd27: k_o = 32'hbf597fc7;
      6'd28: k_o = 32'hc6e00bf3; 6'd29: k_o = 32'hd5a79147; 6'd30: k_o = 32'h06ca6351; 6'd31: k_o = 32'h14292967;
      6'd32: k_o = 32'h27b70a85; 6'd33: k_o = 32'h2e1b2138; 6'd34: k_o = 32'h4d2c6dfc; 6'd35: k_o = 32'h53380d13;
      6'd36: k_o = 32'h650a7354; 6'd37: k_o = 32'h766a0abb; 6'd38: k_o = 32'h81c2c92e; 6'd39: k_o = 32'h92722c85;
      6'd40: k_o = 32'ha2bfe8a1; 6'd41: k_o = 32'ha81a664b; 6'd42: k_o = 32'hc24b8b70; 6'd43: k_o = 32'hc76c51a3;
      6'd44: k_o = 32'hd192e819; 6'd45: k_o = 32'hd6990624; 6'd46: k_o = 32'hf40e3585; 6'd47: k_o = 32'h106aa070;
      6'd48: k_o = 32'h19a4c116; 6'd49: k_o = 32'h1e376c08; 6'd50: k_o = 32'h2748774c; 6'd51: k_o = 32'h34b0bcb5;
      6'd52: k_o = 32'h391c0cb3; 6'd53: k_o = 32'h4ed8aa4a; 6'd54: k_o = 32'h5b9cca4f; 6'd55: k_o = 32'h682e6ff3;
      6'd56: k_o = 32'h748f82ee; 6'd57: k_o = 32'h78a5636f; 6'd58: k_o = 32'h84c87814; 6'd59: k_o = 32'h8cc70208;
      6'd60: k_o = 32'h90befffa; 6'd61: k_o = 32'ha4506ceb; 6'd62: k_o = 32'hbef9a3f7; 6'd63: k_o = 32'hc67178f2;
    endcase
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: loads the core with the IV, paces 64
// rounds on Wt availability, adds the IV back and holds the digest under
// a valid/ack handshake. Optional abort input: SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               ready_o,
  output logic               core_ld_o,
  output logic               core_en_o,
  output logic [31:0]        kt_o,
  input  logic               wt_valid_i,
  output logic               wt_rdy_o,
  output logic [CNT_W-1:0]   round_o,
  input  logic [255:0]       core_state_i,
  output logic [255:0]       digest_o,
  output logic               digest_valid_o,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               digest_ack_i
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [255:0]       digest_q, digest_d;
  logic [255:0]       digest_sum;
  logic [31:0]        k_word;
  logic               in_round;
  logic               abort_act;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_act = abort_i && (state_q != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  sha256_k_rom u_k_rom (
    .idx_i (cnt_q),
    .k_o   (k_word)
  );

  // Per-word feed-forward adders; each lane wraps mod 2^32 independently.
  for (genvar gi = 0; gi < 8; gi++) begin : g_add
    assign digest_sum[255-32*gi -: 32] = IV[gi] + core_state_i[255-32*gi -: 32];
  end

  // Next-state, round counter and digest capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digest_d = digest_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (wt_valid_i) begin
          if (cnt_q == CNT_W'(ROUNDS - 1)) begin
            cnt_d   = '0;
            state_d = ST_FINAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FINAL: begin
        digest_d = digest_sum;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // A start in the same cycle as the ack is deliberately dropped.
        if (digest_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // State, counter and digest registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digest_q <= digest_d;
    end
  end

  assign in_round       = (state_q == ST_ROUND);
  assign ready_o        = (state_q == ST_IDLE);
  assign core_ld_o      = (state_q == ST_LOAD);
  assign core_en_o      = in_round && wt_valid_i && !abort_act;
  assign wt_rdy_o       = core_en_o;
  assign kt_o           = in_round ? k_word : 32'h0;
  assign round_o        = cnt_q;
  assign digest_valid_o = (state_q == ST_DONE);
  assign digest_o       = digest_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a behavioural SHA-256 core and message
// schedule sit around the controller; digests are checked against known
// reference hashes, and timing/handshake corners by directed sequences.
module tb_sha256_round_ctrl;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         ready_o;
  logic         core_ld_o;
  logic         core_en_o;
  logic [31:0]  kt_o;
  logic         wt_valid_i;
  logic         wt_rdy_o;
  logic [5:0]   round_o;
  logic [255:0] core_state_i;
  logic [255:0] digest_o;
  logic         digest_valid_o;
  logic         digest_ack_i;
`ifdef SHA256_CTRL_ABORT_EN
  logic         abort_i;
`endif

  int checks   = 0;
  int failures = 0;

  sha256_round_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .ready_o        (ready_o),
    .core_ld_o      (core_ld_o),
    .core_en_o      (core_en_o),
    .kt_o           (kt_o),
    .wt_valid_i     (wt_valid_i),
    .wt_rdy_o       (wt_rdy_o),
    .round_o        (round_o),
    .core_state_i   (core_state_i),
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o),
`ifdef SHA256_CTRL_ABORT_EN
    .abort_i        (abort_i),
`endif
    .digest_ack_i   (digest_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] IV_TB = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  // ---------------- reference SHA-256 arithmetic ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  logic [31:0]  sched [0:63];
  logic [255:0] core_q;

  task automatic load_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) sched[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3);
      s1 = rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10);
      sched[t] = s1 + sched[t-7] + s0 + sched[t-16];
    end
  endtask

  // Behavioural compression core driven by the controller.
  always @(posedge clk) begin
    if (core_ld_o)      core_q <= IV_TB;
    else if (core_en_o) core_q <= sha_round(core_q, kt_o, sched[round_o]);
  end
  assign core_state_i = core_q;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name, input logic [255:0] exp_dig);
    chk({name, " ready"},   256'(ready_o), 256'(1));
    chk({name, " ld"},      256'(core_ld_o), 256'(0));
    chk({name, " en"},      256'(core_en_o), 256'(0));
    chk({name, " wt_rdy"},  256'(wt_rdy_o), 256'(0));
    chk({name, " kt"},      256'(kt_o), 256'(0));
    chk({name, " round"},   256'(round_o), 256'(0));
    chk({name, " valid"},   256'(digest_valid_o), 256'(0));
    chk({name, " digest"},  digest_o, exp_dig);
  endtask

  // Runs one block from IDLE; entered and left just after a rising edge.
  task automatic run_block(input string name, input logic [511:0] blk, input logic [255:0] exp,
                           input int stall_pct, input int spc, input int ack_delay, input bit aws);
    int cyc, vcnt, exp_round, exp_valid_cyc, got, en_cnt, ld_cnt;
    bit in_win, wv, round_ok, stable_ok, en_ok;
    logic [31:0] kt0, kt63;
    logic [255:0] cap;
    load_sched(blk);
    vcnt = 0; exp_valid_cyc = -1; got = -1; en_cnt = 0; ld_cnt = 0;
    round_ok = 1; stable_ok = 1; en_ok = 1; kt0 = '0; kt63 = '0; exp_round = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      start_i = (cyc == 0) || (cyc == spc);
      wv = (stall_pct > 0) ? ($urandom_range(99) >= stall_pct) : 1'b1;
      wt_valid_i = wv;
      in_win = (cyc >= 2) && (vcnt < 64);
      if (in_win) begin
        exp_round = vcnt;
        if (wv) begin
          vcnt++;
          if (vcnt == 64) exp_valid_cyc = cyc + 2;
        end
      end
      @(negedge clk);
      if (core_en_o) en_cnt++;
      if (core_ld_o) ld_cnt++;
      if (core_ld_o && core_en_o) en_ok = 0;
      if (in_win) begin
        if (round_o != 6'(exp_round) || core_en_o != wv) round_ok = 0;
        if (exp_round == 0)  kt0  = kt_o;
        if (exp_round == 63) kt63 = kt_o;
      end
      if (digest_valid_o) begin
        got = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    start_i = 0;
    chk({name, " timeout"}, 256'(got >= 0), 256'(1));
    if (got < 0) begin
      rst = 1; @(posedge clk); #1; rst = 0;
      return;
    end
    chk({name, " digest"},  digest_o, exp);
    chk({name, " latency"}, 256'(got), 256'(exp_valid_cyc));
    chk({name, " en_cnt"},  256'(en_cnt), 256'(64));
    chk({name, " ld_cnt"},  256'(ld_cnt), 256'(1));
    chk({name, " ld_en_excl"}, 256'(en_ok), 256'(1));
    chk({name, " round_track"}, 256'(round_ok), 256'(1));
    chk({name, " kt0"},  256'(kt0),  256'(32'h428a2f98));
    chk({name, " kt63"}, 256'(kt63), 256'(32'hc67178f2));
    cap = digest_o;
    for (int i = 0; i < ack_delay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!digest_valid_o || digest_o !== cap) stable_ok = 0;
    end
    if (ack_delay > 0) chk({name, " hold_stable"}, 256'(stable_ok), 256'(1));
    @(posedge clk); #1;
    digest_ack_i = 1; start_i = aws;
    @(negedge clk);
    @(posedge clk); #1;
    digest_ack_i = 0; start_i = 0;
    chk({name, " ready_after_ack"}, 256'(ready_o), 256'(1));
    chk({name, " valid_after_ack"}, 256'(digest_valid_o), 256'(0));
    if (aws) begin
      @(negedge clk);
      chk({name, " no_load_after_ack_start"}, 256'(core_ld_o), 256'(0));
      @(posedge clk); #1;
    end
    $display("run %s digest=%h valid_cycle=%0d expected_cycle=%0d en=%0d", name, digest_o, got,
             exp_valid_cyc, en_cnt);
  endtask

  // Starts a run with Wt always ready and stops at the negedge of the target round.
  task automatic start_until_round(input int target, output bit ok);
    ok = 0;
    start_i = 1; wt_valid_i = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (core_en_o && round_o == 6'(target)) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      start_i = 0;
    end
    start_i = 0;
  endtask

  typedef struct {
    logic [511:0] blk;
    logic [255:0] exp;
    int           stall_pct;
    int           spc;
    int           ack_delay;
    bit           aws;
  } vec_t;

  vec_t tbl [4];

  initial begin
    bit ok;
    tbl[0] = '{BLK_ABC,   DIG_ABC,   0,  -1, 0,  1'b0};
    tbl[1] = '{BLK_EMPTY, DIG_EMPTY, 0,  -1, 0,  1'b0};
    tbl[2] = '{BLK_ABC,   DIG_ABC,   50, -1, 0,  1'b0};
    tbl[3] = '{BLK_EMPTY, DIG_EMPTY, 0,  20, 10, 1'b1};

    rst = 1; start_i = 0; wt_valid_i = 1; digest_ack_i = 0;
`ifdef SHA256_CTRL_ABORT_EN
    abort_i = 0;
`endif
    load_sched(BLK_ABC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset", 256'h0);
    @(posedge clk); #1;
    rst = 0; wt_valid_i = 0;

    for (int v = 0; v < 4; v++) begin
      run_block($sformatf("vec%0d", v), tbl[v].blk, tbl[v].exp, tbl[v].stall_pct,
                tbl[v].spc, tbl[v].ack_delay, tbl[v].aws);
    end

    // Reset in the middle of round 30, then a full rerun.
    load_sched(BLK_ABC);
    start_until_round(30, ok);
    chk("reach_round30", 256'(ok), 256'(1));
    rst = 1;
    #1;
    chk_idle("midrun_reset", 256'h0);
    @(posedge clk); #1;
    rst = 0; wt_valid_i = 0;
    $display("run midrun_reset at round 30");
    run_block("after_reset", BLK_ABC, DIG_ABC, 0, -1, 0, 1'b0);

`ifdef SHA256_CTRL_ABORT_EN
    load_sched(BLK_ABC);
    start_until_round(40, ok);
    chk("reach_round40", 256'(ok), 256'(1));
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0; wt_valid_i = 0;
    chk("abort ready",  256'(ready_o), 256'(1));
    chk("abort valid",  256'(digest_valid_o), 256'(0));
    chk("abort round",  256'(round_o), 256'(0));
    chk("abort digest", digest_o, DIG_ABC);
    $display("run abort at round 40");
    run_block("after_abort", BLK_ABC, DIG_ABC, 0, -1, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath (`sha256_hash_core`).
- Accepts a start request and loads the core with the initial hash values.
- Steps the core through 64 rounds, supplying the round constant Kt and pacing each round on availability of the message word Wt.
- Performs the final IV addition and presents a 256-bit digest under a valid/ack handshake.
- One 512-bit block per start; sits between the message-schedule block and the host interface.

## Interface
- ROUNDS, 64, number of compression rounds; fixed at 64 for SHA-256, exposed only for index-width derivation.
- CNT_W, $clog2(ROUNDS), round counter width.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only while ready_o=1.
- ready_o  out  1  controller idle; start_i is accepted this cycle.
- core_ld_o  out  1  drives core ld_i; loads IV into a..h.
- core_en_o  out  1  drives core en_i; one round executes per asserted cycle.
- kt_o  out  32  round constant K[round_o] to core Kt_i.
- wt_valid_i  in  1  message schedule has Wt for the current round.
- wt_rdy_o  out  1  Wt consumed this cycle.
- round_o  out  CNT_W  current round index t.
- core_state_i  in  256  core outputs {A,B,C,D,E,F,G,H}; A occupies [255:224].
- digest_o  out  256  final digest {H0..H7}; H0 occupies [255:224].
- digest_valid_o  out  1  digest_o is valid.
- digest_ack_i  in  1  host accepts the digest.
- abort_i  in  1  present only with SHA256_CTRL_ABORT_EN.

## Operation
States are IDLE, LOAD, ROUND, FINAL and DONE.

- **IDLE**
  - ready_o=1.
  - start_i=1 → LOAD.
- **LOAD**
  - core_ld_o=1 for exactly one cycle.
  - cnt←0.
  - → ROUND.
- **ROUND**
  - kt_o=K[cnt]; round_o=cnt.
  - core_en_o=wt_rdy_o=wt_valid_i.
  - When wt_valid_i=0: the core stalls and cnt holds.
  - On an enabled cycle with cnt<63: cnt←cnt+1.
  - On an enabled cycle with cnt=63: → FINAL, and cnt wraps to 0.
- **FINAL**
  - digest_o[i] ← (IV[i] + core_state_i[i]) mod 2^32 for each of the 8 words independently; no carry between words.
  - → DONE.
- **DONE**
  - digest_valid_o=1, held until digest_ack_i=1, then → IDLE.
  - digest_o holds its value until the next FINAL.

Boundary conditions:
- start_i outside IDLE is ignored, including start_i and digest_ack_i in the same cycle in DONE: that cycle goes to IDLE, and the start must be re-asserted.
- digest_ack_i outside DONE is ignored.
- In all states other than ROUND: core_en_o=0, wt_rdy_o=0, kt_o=0.
- core_ld_o and core_en_o are never high together.
- Reset mid-operation returns to IDLE immediately. The core is reloaded on the next start, so partial rounds are discarded.
- Reset values: state=IDLE, cnt=0, ready_o=1, core_ld_o=0, core_en_o=0, wt_rdy_o=0, kt_o=0, round_o=0, digest_o=0, digest_valid_o=0.

## Timing
- All state and the digest register are flopped; control outputs are decoded from state plus wt_valid_i.
- kt_o and round_o are decoded from the cnt register.
- With start_i at cycle 0 and no stalls:
  - LOAD in cycle 1.
  - ROUND in cycles 2–65.
  - FINAL in cycle 66.
  - digest_valid_o first high in cycle 67.
  - Total latency is 67 cycles + stall cycles.
- The earliest next start is the cycle after digest_ack_i is seen.

## Configuration
- Macro: SHA256_CTRL_ABORT_EN.
- **Defined**
  - Adds input abort_i.
  - abort_i=1 in any state other than IDLE → IDLE on the next edge, with cnt←0 and digest_valid_o←0.
  - digest_o is unchanged by abort.
  - abort_i has priority over start_i, wt_valid_i and digest_ack_i.
  - abort_i in IDLE has no effect.
- **Undefined**
  - No abort_i port.
  - Once started, the FSM runs to DONE.

## Structure
- Package sha256_pkg:
  - K[0:63] constant array of 32-bit words.
  - IV[0:7] constant array.
  - State enum type.
  - Localparam ROUNDS.
- Sub-module sha256_k_rom: combinational lookup, 6-bit index → 32-bit K, case-based.
- Control FSM, round counter and digest adder live in sha256_round_ctrl.

## Test plan
- **Single block "abc"** (padded block from a reference schedule model), wt_valid_i always 1 → digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid_o first high 67 cycles after start.
- **Empty message** (padded block 80000000, 0…0) → digest_o = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Random wt_valid_i stalls** (≈50% duty) on "abc":
  - Digest is unchanged.
  - Count of core_en_o cycles = 64.
  - round_o never advances on stall cycles.
  - kt_o at round 0 = 428a2f98 and at round 63 = c67178f2.
- **Handshake rules:**
  - start_i pulsed during ROUND is ignored.
  - digest_ack_i held low for 10 cycles → digest_valid_o and digest_o stable.
  - start_i and digest_ack_i together in DONE → IDLE, and no LOAD occurs.
- **Reset asserted at round 30:**
  - All outputs return to reset values asynchronously.
  - A subsequent "abc" run yields the correct digest.
- **With SHA256_CTRL_ABORT_EN, abort_i at round 40:**
  - Next cycle is IDLE and ready_o=1.
  - digest_o keeps the previous digest.
  - A restart produces the correct "abc" digest.
